// File: rtl/burst_sink_unit.sv
// Burst sink at a router local port: delimits bursts on tlast, counts beats, flags stalls.
// Define BURST_SINK_SEQ_CHECK_EN to enable payload sequence checking and seq_error.
module burst_sink_unit #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int ERR_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [8:0]       flit_in,
    input  logic             flit_valid,
    output logic             flit_ready,
    output logic [7:0]       data_latched,
    output logic             data_strobe,
    output logic             burst_done,
    output logic [LEN_W-1:0] last_burst_len,
    output logic [15:0]      burst_count,
    output logic             seq_error,
    output logic             timeout_error,
    output logic [ERR_W-1:0] error_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0]      TIMEOUT_M1 = 16'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] BEAT_MAX   = '1;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] beat_inc;
    logic [15:0]      timer;
    logic             accept;
    logic             tlast;
    logic [7:0]       payload;
    logic             timeout_hit;
    logic             seq_mis;
    logic             err_evt;

    assign accept  = flit_valid & flit_ready;
    assign tlast   = flit_in[8];
    assign payload = flit_in[7:0];

    // An accept in the final idle cycle keeps the burst alive.
    assign timeout_hit = (state == RECV) && !accept && (timer == TIMEOUT_M1);

    always_comb begin
        beat_inc = beat;
        if (state == IDLE)
            beat_inc = LEN_W'(1);
        else if (beat != BEAT_MAX)
            beat_inc = beat + LEN_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = tlast ? DONE : RECV;
            end
            RECV: begin
                if (accept && tlast)
                    state_nxt = DONE;
                else if (timeout_hit)
                    state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        flit_ready = (state != DONE);
        burst_done = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat           <= '0;
            timer          <= '0;
            data_latched   <= '0;
            data_strobe    <= 1'b0;
            last_burst_len <= '0;
            burst_count    <= '0;
            timeout_error  <= 1'b0;
        end else begin
            data_strobe   <= accept;
            timeout_error <= timeout_hit;
            if (accept)
                data_latched <= payload;
            if (state == RECV && !accept)
                timer <= timeout_hit ? 16'd0 : timer + 16'd1;
            else
                timer <= '0;
            if (accept)
                beat <= beat_inc;
            else if (timeout_hit || state == DONE)
                beat <= '0;
            if (accept && tlast) begin
                last_burst_len <= beat_inc;
                burst_count    <= burst_count + 16'd1;
            end
        end
    end

`ifdef BURST_SINK_SEQ_CHECK_EN
    logic [7:0] expected;

    // Payload 0 never matches since expected stays within 1..255.
    assign seq_mis = accept && (payload != expected);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            expected  <= 8'd1;
            seq_error <= 1'b0;
        end else begin
            seq_error <= seq_mis;
            if (accept)
                expected <= (payload == 8'hFF) ? 8'd1 : payload + 8'd1;
            else if (state == DONE || timeout_hit)
                expected <= 8'd1;
        end
    end
`else
    assign seq_mis   = 1'b0;
    assign seq_error = 1'b0;
`endif

    assign err_evt = seq_mis | timeout_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            error_count <= '0;
        else if (err_evt && error_count != {ERR_W{1'b1}})
            error_count <= error_count + ERR_W'(1);
    end

endmodule

// File: tb/tb_burst_sink_unit.sv
// Directed and randomized bench for burst_sink_unit against a burst-level model.
module tb_burst_sink_unit;

    localparam int TIMEOUT = 64;
`ifdef BURST_SINK_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  flit_in = '0;
    logic        flit_valid = 1'b0;
    logic        flit_ready;
    logic [7:0]  data_latched;
    logic        data_strobe;
    logic        burst_done;
    logic [15:0] last_burst_len;
    logic [15:0] burst_count;
    logic        seq_error;
    logic        timeout_error;
    logic [7:0]  error_count;

    burst_sink_unit #(.LEN_W(16), .TIMEOUT(TIMEOUT), .ERR_W(8)) dut (
        .clock(clock),
        .reset(reset),
        .flit_in(flit_in),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .data_latched(data_latched),
        .data_strobe(data_strobe),
        .burst_done(burst_done),
        .last_burst_len(last_burst_len),
        .burst_count(burst_count),
        .seq_error(seq_error),
        .timeout_error(timeout_error),
        .error_count(error_count)
    );

    always #5 clock = ~clock;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    int  m_exp, m_beat, m_bursts, m_err, m_last_len;
    time last_t = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_exp = 1; m_beat = 0; m_bursts = 0; m_err = 0; m_last_len = 0;
    endtask

    function automatic int nxt(input int p);
        return (p == 255) ? 1 : p + 1;
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        flit_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_ready", flit_ready, 1);
        check("rst_data", data_latched, 0);
        check("rst_strobe", data_strobe, 0);
        check("rst_done", burst_done, 0);
        check("rst_len", last_burst_len, 0);
        check("rst_count", burst_count, 0);
        check("rst_seq", seq_error, 0);
        check("rst_to", timeout_error, 0);
        check("rst_err", error_count, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [7:0] p, input logic last, output int gap);
        int  waits = 0;
        bit  mis;
        @(negedge clock);
        flit_in = {last, p};
        flit_valid = 1'b1;
        while (!flit_ready && waits < 8) begin
            @(negedge clock);
            waits++;
        end
        if (!flit_ready) check("ready_wait", flit_ready, 1);
        @(posedge clock);
        gap = int'(($time - last_t) / 10);
        last_t = $time;
        #1;
        mis = SEQ_EN && (int'(p) != m_exp);
        if (mis) bump_err();
        m_exp = nxt(p);
        if (m_beat < 65535) m_beat++;
        check("strobe", data_strobe, 1);
        check("data", data_latched, p);
        check("seq_err", seq_error, mis);
        check("err_cnt", error_count, m_err);
        if (last) begin
            m_bursts = (m_bursts + 1) & 16'hFFFF;
            m_last_len = m_beat;
            m_beat = 0;
            m_exp = 1;
            check("done", burst_done, 1);
            check("len", last_burst_len, m_last_len);
            check("bcount", burst_count, m_bursts);
            check("ready_done", flit_ready, 0);
        end else begin
            check("no_done", burst_done, 0);
            check("ready_recv", flit_ready, 1);
        end
    endtask

    task automatic stop();
        @(negedge clock);
        flit_valid = 1'b0;
        @(posedge clock);
        #1;
        check("strobe_idle", data_strobe, 0);
        check("done_idle", burst_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int p;
        int len;
        model_reset();
        do_reset();

        send(8'd1, 1'b0, g);
        send(8'd2, 1'b0, g);
        send(8'd3, 1'b1, g);
        stop();

        for (int i = 0; i < 300; i++)
            send(8'((i % 255) + 1), i == 299, g);
        stop();
        check("wrap_len", last_burst_len, 300);

        send(8'd1, 1'b0, g);
        send(8'd2, 1'b0, g);
        send(8'd5, 1'b0, g);
        send(8'd6, 1'b1, g);
        stop();

        send(8'd1, 1'b0, g);
        stop();
        for (int i = 2; i <= TIMEOUT; i++) begin
            @(posedge clock);
            #1;
            check("to_pulse", timeout_error, i == TIMEOUT);
        end
        m_exp = 1;
        m_beat = 0;
        bump_err();
        check("to_err_cnt", error_count, m_err);
        check("to_ready", flit_ready, 1);
        @(posedge clock);
        #1;
        check("to_single", timeout_error, 0);
        send(8'd1, 1'b1, g);
        stop();

        send(8'd1, 1'b0, g);
        send(8'd2, 1'b0, g);
        do_reset();
        send(8'd1, 1'b0, g);
        send(8'd2, 1'b1, g);
        stop();

        do_reset();
        for (int k = 0; k < 300; k++) begin
            send(8'd7, 1'b1, g);
            if (k > 0) check("b2b_gap", g, 2);
        end
        stop();
        check("sat_err", error_count, SEQ_EN ? 255 : 0);
        check("sat_bursts", burst_count, 300);

        do_reset();
        for (int b = 0; b < 20; b++) begin
            len = $urandom_range(1, 6);
            p = $urandom_range(1, 255);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0)
                    p = $urandom_range(0, 255);
                send(8'(p), j == len - 1, g);
                p = nxt(p);
            end
        end
        stop();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/burst_sink_unit.md
Name: burst_sink_unit

Overview:
- Receive-side processing element at a router's local port; the consumer end of the processor-to-router flit stream.
- Accepts 9-bit flits {tlast, payload[7:0]}, where the payload is a burst sequence number counting 1..255 and wrapping 255->1 (0 is never used).
- Delimits bursts on tlast, measures burst length, checks sequence continuity and flags stalled bursts.
- Reports per-burst and cumulative status to the local processor.

Parameters:
- LEN_W, 16, width of the burst beat counter and of last_burst_len.
- TIMEOUT, 64, cycles with no accepted flit while inside a burst before that burst is aborted; legal range 2..65535.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flit_in  in  9  flit from router; [8] = tlast, [7:0] = payload
- flit_valid  in  1  flit_in holds a valid flit this cycle
- flit_ready  out  1  sink can accept; a flit transfers when flit_valid & flit_ready at a rising edge
- data_latched  out  8  payload of the most recently accepted flit
- data_strobe  out  1  one-cycle pulse: data_latched was updated at the preceding edge
- burst_done  out  1  one-cycle pulse: a burst closed with tlast
- last_burst_len  out  LEN_W  beat count of the most recently completed burst
- burst_count  out  16  completed bursts, wraps 0xFFFF->0
- seq_error  out  1  one-cycle pulse: accepted payload did not equal the expected sequence number
- timeout_error  out  1  one-cycle pulse: burst aborted by timeout
- error_count  out  ERR_W  seq plus timeout errors, saturates at all-ones

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE, flit_ready=1.
  - All other outputs 0.
  - Internal: beat=0, expected=1, idle timer=0.
- States:
  - IDLE: flit_ready=1. On accept: beat=1. If tlast=1 go to DONE (single-flit burst), else go to RECV.
  - RECV: flit_ready=1.
    - On accept: beat=beat+1, saturating at 2^LEN_W-1; idle timer cleared.
    - On accept with tlast=1: go to DONE.
    - With no accept: timer increments. When it reaches TIMEOUT-1 and still no accept: timeout_error=1, error_count+1, beat cleared, expected=1, go to IDLE.
    - Accept and timeout in the same cycle: the accept wins and no timeout fires.
  - DONE: exactly one cycle.
    - flit_ready=0, burst_done=1.
    - last_burst_len and burst_count are already updated at the edge entering DONE, so they are valid while burst_done is high.
    - Next state is IDLE, with expected=1.
- Data path: on every accept, data_latched<=flit_in[7:0] and data_strobe=1 for the following cycle. Latency is one cycle.
- Sequence tracking:
  - expected is 1 at the start of each burst.
  - After each accept, expected<=next(payload), where next(255)=1 and next(x)=x+1. This resynchronises the tracker after an error.
  - Payload 0 is always a mismatch.
- Error pulse timing: seq_error pulses the cycle after the offending accept. Mismatches on the tlast flit are still reported, in the same cycle as burst_done.
- error_count:
  - Increments once per seq_error or timeout_error pulse.
  - When both pulse in the same cycle (cannot occur by construction), it increments by 1.
  - Saturates at all-ones and never wraps.
- flit_valid while flit_ready=0 (DONE): nothing is accepted; the flit must be held by the router.

Optional Feature:
- Macro: BURST_SINK_SEQ_CHECK_EN.
- Defined: sequence tracking and seq_error are as described above.
- Undefined: no expected-value logic; seq_error is tied to 0; error_count counts timeouts only. All other behaviour is identical.

Test Plan:
- Single burst: flits 1,2,3 with tlast on 3, valid every cycle -> data_strobe x3; burst_done one cycle after the third accept; last_burst_len=3; burst_count=1; seq_error never asserted; flit_ready=0 only in the DONE cycle.
- Wrap burst: 300 flits with payloads 1..255 then 1..45, tlast on the last -> no seq_error; last_burst_len=300.
- Sequence fault: 1,2,5,6 with tlast on 6 (macro defined) -> seq_error exactly once, the cycle after 5 is accepted; error_count=1; 6 is accepted without error. Macro undefined -> seq_error stays 0, error_count=0.
- Timeout: flit 1 without tlast, then idle for TIMEOUT=64 cycles -> timeout_error pulses once; error_count=1; state returns to IDLE; the next flit 1 starts a fresh burst with no seq_error.
- Reset mid-burst: assert reset after 2 of 4 flits -> all outputs 0 immediately; a following 2-flit burst gives last_burst_len=2, burst_count=1.
- Saturation and back-to-back: 300 single-flit bursts of payload 7 (macro defined) -> error_count stops at 255; flit_valid held high produces one accept every two cycles; burst_count=300.
